// File: rtl/camera_value_regbank.sv
// AXI4-Lite register bank: NUM_REGS words of DW bits with byte strobes and read-only status slots.
// Writes commit one edge after both AW and W are held; reads respond one edge after the AR handshake.
module camera_value_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH / 8),
  parameter logic [63:0] RO_MASK = 64'hC0,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]                      reg_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_in
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  // Read-only slots keep a constant zero entry so reg_out reads 0 there.
  logic [DW-1:0] regs [NUM_REGS];

  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic [NUM_REGS-1:0] wr_sel;
  logic                wr_hit;
  logic [IW-1:0]       ar_idx;
  logic                rd_hit;
  logic [DW-1:0]       rd_val;

  assign ar_idx = S_AXI_ARADDR[AW-1:LSB];

  // Out-of-range indices match no slot, so they fall out as misses.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IW'(i) && !RO_MASK[i]) wr_sel[i] = 1'b1;
    end
    wr_hit = |wr_sel;
  end

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = regs[i];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate        <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      reg_wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DW +: DW];
      end
    end else begin
      reg_wr_pulse <= '0;
      case (wstate)
        W_IDLE, W_COLLECT: begin
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_idx        <= S_AXI_AWADDR[AW-1:LSB];
            aw_held       <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
          end else if (!aw_held) begin
            S_AXI_AWREADY <= 1'b1;
          end

          if (S_AXI_WVALID && S_AXI_WREADY) begin
            wdata_q      <= S_AXI_WDATA;
            wstrb_q      <= S_AXI_WSTRB;
            w_held       <= 1'b1;
            S_AXI_WREADY <= 1'b0;
          end else if (!w_held) begin
            S_AXI_WREADY <= 1'b1;
          end

          if (aw_held && w_held) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              for (int b = 0; b < SW; b++) begin
                if (wr_sel[i] && wstrb_q[b]) regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
              end
            end
            reg_wr_pulse <= wr_sel;
            S_AXI_BRESP  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            S_AXI_BVALID <= 1'b1;
            wstate       <= W_RESP;
          end else if ((S_AXI_AWVALID && S_AXI_AWREADY) || (S_AXI_WVALID && S_AXI_WREADY)) begin
            wstate <= W_COLLECT;
          end
        end

        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wstate        <= W_IDLE;
          end
        end

        default: wstate <= W_IDLE;
      endcase
    end
  end

  // A read sampled on the same edge as a commit sees the pre-write value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RDATA   <= rd_val;
            S_AXI_RRESP   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            rstate        <= R_RESP;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end

        R_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rstate        <= R_IDLE;
          end
        end

        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], status_in};

endmodule

// File: tb/tb_camera_value_regbank.sv
// Randomized and directed bench for camera_value_regbank against a word/byte-level register model.
module tb_camera_value_regbank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 8;
  localparam logic [7:0] RO = 8'hC0;
  localparam logic [NR*DW-1:0] RST_VAL = {32'hA5000007, 32'hA5000006, 32'hA5000005, 32'hA5000004,
                                          32'hA5000003, 32'hA5000002, 32'hA5000001, 32'hA5000000};

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b1;
  logic [AW-1:0]  S_AXI_AWADDR = '0;
  logic [2:0]     S_AXI_AWPROT = '0;
  logic           S_AXI_AWVALID = 1'b0;
  logic           S_AXI_AWREADY;
  logic [DW-1:0]  S_AXI_WDATA = '0;
  logic [3:0]     S_AXI_WSTRB = '0;
  logic           S_AXI_WVALID = 1'b0;
  logic           S_AXI_WREADY;
  logic [1:0]     S_AXI_BRESP;
  logic           S_AXI_BVALID;
  logic           S_AXI_BREADY = 1'b0;
  logic [AW-1:0]  S_AXI_ARADDR = '0;
  logic [2:0]     S_AXI_ARPROT = '0;
  logic           S_AXI_ARVALID = 1'b0;
  logic           S_AXI_ARREADY;
  logic [DW-1:0]  S_AXI_RDATA;
  logic [1:0]     S_AXI_RRESP;
  logic           S_AXI_RVALID;
  logic           S_AXI_RREADY = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]  reg_wr_pulse;
  logic [NR*DW-1:0] status_in = '0;

  camera_value_regbank #(
    .C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(AW),
    .RO_MASK(64'hC0), .RESET_VAL(RST_VAL)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse),
    .status_in(status_in)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [NR];
  int pulse_cnt [NR] = '{default: 0};

  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
  end

  // ---------------- reference model ----------------
  function automatic void mdl_reset();
    for (int i = 0; i < NR; i++) model[i] = RST_VAL[i*DW +: DW];
  endfunction

  function automatic void mdl_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                                    input logic [3:0] s, output logic [1:0] resp,
                                    output logic [NR-1:0] pulse);
    int idx = int'(addr) / 4;
    pulse = '0;
    resp = 2'b10;
    if (idx < NR) begin
      if (!RO[idx]) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        resp = 2'b00;
        pulse[idx] = 1'b1;
      end
    end
  endfunction

  function automatic void mdl_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                                   output logic [1:0] resp);
    int idx = int'(addr) / 4;
    d = '0;
    resp = 2'b10;
    if (idx < NR) begin
      d = RO[idx] ? status_in[idx*DW +: DW] : model[idx];
      resp = 2'b00;
    end
  endfunction

  function automatic logic [NR*DW-1:0] exp_reg_out();
    logic [NR*DW-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? '0 : model[i];
    return v;
  endfunction

  function automatic int pulse_total();
    int t = 0;
    for (int i = 0; i < NR; i++) t += pulse_cnt[i];
    return t;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int d_aw, input int d_w, input int b_hold,
                           output logic [1:0] resp, output int lat, output bit hold_ok,
                           output logic [NR-1:0] pulse_at_b, output bit rdy_after);
    bit to_aw = 1'b1, to_w = 1'b1, to_b = 1'b1;
    @(negedge ACLK);
    fork
      begin
        repeat (d_aw) @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        for (int k = 0; k < 50; k++) begin
          if (S_AXI_AWREADY) begin to_aw = 1'b0; break; end
          @(negedge ACLK);
        end
        @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
      end
      begin
        repeat (d_w) @(negedge ACLK);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int k = 0; k < 50; k++) begin
          if (S_AXI_WREADY) begin to_w = 1'b0; break; end
          @(negedge ACLK);
        end
        @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
      end
    join
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK); lat++;
      if (S_AXI_BVALID) begin to_b = 1'b0; break; end
    end
    resp = S_AXI_BRESP;
    pulse_at_b = reg_wr_pulse;
    hold_ok = !(S_AXI_AWREADY || S_AXI_WREADY);
    for (int k = 0; k < b_hold; k++) begin
      @(negedge ACLK);
      if (!S_AXI_BVALID || S_AXI_BRESP !== resp || S_AXI_AWREADY || S_AXI_WREADY) hold_ok = 1'b0;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    rdy_after = S_AXI_AWREADY && S_AXI_WREADY && !S_AXI_BVALID;
    checks++;
    if (to_aw || to_w || to_b) begin
      errors++;
      $display("FAIL write_timeout: addr=%h aw=%0b w=%0b b=%0b stuck, required all handshakes", addr, to_aw, to_w, to_b);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_hold,
                          output logic [DW-1:0] data, output logic [1:0] resp, output int lat,
                          output bit hold_ok, output bit rdy_after);
    bit to_ar = 1'b1, to_r = 1'b1;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (S_AXI_ARREADY) begin to_ar = 1'b0; break; end
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK); lat++;
      if (S_AXI_RVALID) begin to_r = 1'b0; break; end
    end
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    hold_ok = !S_AXI_ARREADY;
    for (int k = 0; k < r_hold; k++) begin
      // Status moves under a held response; the returned word must not.
      if (k == 0) status_in = ~status_in;
      @(negedge ACLK);
      if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp || S_AXI_ARREADY) hold_ok = 1'b0;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    rdy_after = S_AXI_ARREADY && !S_AXI_RVALID;
    checks++;
    if (to_ar || to_r) begin
      errors++;
      $display("FAIL read_timeout: addr=%h ar=%0b r=%0b stuck, required both handshakes", addr, to_ar, to_r);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 ARESETN = 1'b0;
    mdl_reset();
    repeat (3) @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_hs: got %b want 00000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    checks++;
    if (S_AXI_RDATA !== '0 || S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00 || reg_wr_pulse !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b pulse=%b want zeros",
        S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP, reg_wr_pulse);
    end
    checks++;
    if (reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL reset_regs: got %h want %h", reg_out, exp_reg_out());
    end
    ARESETN = 1'b1;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_early: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_rise: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; logic [DW-1:0] d, ed; int lat, p0; bit hok, rdy;
    for (int i = 0; i < 4; i++) begin
      p0 = pulse_total();
      mdl_write(AW'(i*4), DW'(i+1), 4'hF, er, ep);
      axi_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 1, r, lat, hok, pv, rdy);
      checks++;
      if (r !== er || pv !== ep || lat != 2 || pulse_total() - p0 != 1 || !hok || !rdy) begin
        errors++; $display("FAIL basic_wr%0d: resp=%b pulse=%b lat=%0d npulse=%0d hold=%0b rdy=%0b want resp=%b pulse=%b lat=2 npulse=1 1 1",
          i, r, pv, lat, pulse_total() - p0, hok, rdy, er, ep);
      end
    end
    for (int i = 0; i < 4; i++) begin
      mdl_read(AW'(i*4), ed, er);
      axi_read(AW'(i*4), 0, d, r, lat, hok, rdy);
      checks++;
      if (d !== ed || r !== er || lat != 1 || !rdy) begin
        errors++; $display("FAIL basic_rd%0d: data=%h resp=%b lat=%0d rdy=%0b want data=%h resp=%b lat=1 rdy=1",
          i, d, r, lat, rdy, ed, er);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; logic [DW-1:0] d; int lat; bit hok, rdy;
    mdl_write(8'h04, 32'hAABBCCDD, 4'b0101, er, ep);
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, r, lat, hok, pv, rdy);
    axi_read(8'h04, 0, d, r, lat, hok, rdy);
    checks++;
    if (d !== 32'h00BB00DD || r !== 2'b00) begin
      errors++; $display("FAIL strobe_merge: data=%h resp=%b want 00bb00dd 00", d, r);
    end
    mdl_write(8'h04, 32'h11111111, 4'b0000, er, ep);
    axi_write(8'h04, 32'h11111111, 4'b0000, 0, 0, 0, r, lat, hok, pv, rdy);
    checks++;
    if (r !== 2'b00 || pv !== 8'h02 || reg_out[63:32] !== 32'h00BB00DD) begin
      errors++; $display("FAIL strobe_zero: resp=%b pulse=%b reg1=%h want 00 00000010 00bb00dd", r, pv, reg_out[63:32]);
    end
  endtask

  task automatic test_read_only();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; logic [DW-1:0] d, ed; int lat, p0; bit hok, rdy;
    status_in[6*DW +: DW] = 32'hDEADBEEF;
    p0 = pulse_total();
    mdl_write(8'h18, 32'h12345678, 4'hF, er, ep);
    axi_write(8'h18, 32'h12345678, 4'hF, 0, 0, 0, r, lat, hok, pv, rdy);
    checks++;
    if (r !== 2'b10 || pv !== '0 || pulse_total() != p0 || reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL ro_write: resp=%b pulse=%b npulse=%0d want 10 0 0", r, pv, pulse_total() - p0);
    end
    mdl_read(8'h18, ed, er);
    axi_read(8'h18, 2, d, r, lat, hok, rdy);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || !hok) begin
      errors++; $display("FAIL ro_read: data=%h resp=%b hold=%0b want deadbeef 00 1", d, r, hok);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; logic [DW-1:0] d, ed; int lat, p0; bit hok, rdy;
    axi_read(8'h40, 0, d, r, lat, hok, rdy);
    checks++;
    if (d !== '0 || r !== 2'b10) begin
      errors++; $display("FAIL oor_read: data=%h resp=%b want 0 10", d, r);
    end
    mdl_read(8'h00, ed, er);
    axi_read(8'h00, 0, d, r, lat, hok, rdy);
    checks++;
    if (d !== ed || r !== 2'b00) begin
      errors++; $display("FAIL oor_recover: data=%h resp=%b want %h 00", d, r, ed);
    end
    p0 = pulse_total();
    mdl_write(8'h44, 32'hFFFFFFFF, 4'hF, er, ep);
    axi_write(8'h44, 32'hFFFFFFFF, 4'hF, 1, 0, 0, r, lat, hok, pv, rdy);
    checks++;
    if (r !== 2'b10 || pulse_total() != p0 || reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL oor_write: resp=%b npulse=%0d want 10 0", r, pulse_total() - p0);
    end
  endtask

  task automatic test_w_first_bhold();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; int lat; bit hok, rdy;
    mdl_write(8'h0C, 32'hCAFEF00D, 4'hF, er, ep);
    axi_write(8'h0C, 32'hCAFEF00D, 4'hF, 3, 0, 5, r, lat, hok, pv, rdy);
    checks++;
    if (lat != 2 || !hok || !rdy || r !== 2'b00 || pv !== ep || reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL w_first: lat=%0d hold=%0b rdy=%0b resp=%b pulse=%b want lat=2 1 1 00 %b",
        lat, hok, rdy, r, pv, ep);
    end
  endtask

  task automatic test_back_to_back_rw();
    logic [1:0] r, rr, er, wer; logic [NR-1:0] pv, ep; logic [DW-1:0] d, old, ed; int lat, rlat;
    bit hok, rdy, rhok, rrdy;
    mdl_read(8'h08, old, er);
    mdl_write(8'h08, 32'h00000055, 4'hF, wer, ep);
    fork
      axi_write(8'h08, 32'h00000055, 4'hF, 0, 0, 0, r, lat, hok, pv, rdy);
      begin @(negedge ACLK); axi_read(8'h08, 0, d, rr, rlat, rhok, rrdy); end
    join
    checks++;
    if (d !== old || rr !== 2'b00 || r !== wer) begin
      errors++; $display("FAIL same_edge: rdata=%h rresp=%b bresp=%b want %h 00 %b", d, rr, r, old, wer);
    end
    mdl_read(8'h08, ed, er);
    axi_read(8'h08, 0, d, rr, rlat, rhok, rrdy);
    checks++;
    if (d !== ed) begin
      errors++; $display("FAIL same_edge_after: rdata=%h want %h", d, ed);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [NR-1:0] pv, ep; logic [DW-1:0] d, ed, wd; logic [AW-1:0] a;
    logic [3:0] s; int lat, hold; bit hok, rdy;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom;
      a = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        mdl_write(a, wd, s, er, ep);
        axi_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), hold, r, lat, hok, pv, rdy);
        checks++;
        if (r !== er || pv !== ep || lat != 2 || !hok || !rdy) begin
          errors++; $display("FAIL rand_wr%0d: addr=%h resp=%b pulse=%b lat=%0d hold=%0b rdy=%0b want %b %b 2 1 1",
            it, a, r, pv, lat, hok, rdy, er, ep);
        end
      end else begin
        mdl_read(a, ed, er);
        axi_read(a, hold, d, r, lat, hok, rdy);
        checks++;
        if (d !== ed || r !== er || lat != 1 || !hok || !rdy) begin
          errors++; $display("FAIL rand_rd%0d: addr=%h data=%h resp=%b lat=%0d hold=%0b rdy=%0b want %h %b 1 1 1",
            it, a, d, r, lat, hok, rdy, ed, er);
        end
      end
    end
    checks++;
    if (reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL rand_regs: got %h want %h", reg_out, exp_reg_out());
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r; logic [DW-1:0] d; int lat; bit hok, rdy;
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 8'h04;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if (!(S_AXI_BVALID && S_AXI_RVALID)) begin
      errors++; $display("FAIL midflight_setup: bvalid=%b rvalid=%b want 1 1", S_AXI_BVALID, S_AXI_RVALID);
    end
    #2 ARESETN = 1'b0;
    mdl_reset();
    #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 5'b0 ||
        S_AXI_RDATA !== '0 || reg_out !== exp_reg_out()) begin
      errors++; $display("FAIL midflight_reset: hs=%b rdata=%h regs=%h want 00000 0 %h",
        {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, S_AXI_RDATA, reg_out, exp_reg_out());
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
      errors++; $display("FAIL midflight_release: got %b want 11100",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    axi_read(8'h00, 0, d, r, lat, hok, rdy);
    checks++;
    if (d !== 32'hA5000000 || r !== 2'b00) begin
      errors++; $display("FAIL midflight_readback: data=%h resp=%b want a5000000 00", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_read_only();
    test_out_of_range();
    test_w_first_bhold();
    test_back_to_back_rw();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
